// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    // One prefetched instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0 - presented to decode whenever nothing is buffered
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer holding fetched entries until decode takes them
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         almost_full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

    fetch_entry_t     mem_q [BUF_DEPTH];
    fetch_entry_t     mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer, count and storage updates; flush discards everything in one cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: it is only visible through a non-empty count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Occupancy state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q == DEPTH_C - 1'b1);
    assign empty       = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - sequential instruction fetch with prefetch buffer and redirect
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned
);

    logic [31:0]  pc_q, pc_d;
    logic         mis_q, mis_d;
    fetch_state_t state_q, state_d;

    logic         full, almost_full, empty;
    logic         push, pop;
    fetch_entry_t head, push_entry;

    // A redirect outranks both buffer movements in its cycle
    assign pop        = !empty && instr_ready && !redirect_valid;
    assign push       = fetch_en && !redirect_valid && (!full || pop);
    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .wdata      (push_entry),
        .full       (full),
        .almost_full(almost_full),
        .empty      (empty),
        .head       (head)
    );

    // Next fetch address: redirect target (word aligned) or sequential, wrapping at 2^32
    always_comb begin
        pc_d  = pc_q;
        mis_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch state: idle when disabled, hold while the buffer is full and undrained
    always_comb begin
        state_d = state_q;
        if (!fetch_en) begin
            state_d = ST_IDLE;
        end else if (redirect_valid) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_HOLD: state_d = pop ? ST_FETCH : ST_HOLD;
                default: state_d = (!pop && (full || (push && almost_full))) ? ST_HOLD : ST_FETCH;
            endcase
        end
    end

    // Control registers, cleared asynchronously so nothing in flight survives reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            state_q <= state_d;
        end
    end

    assign imem_addr   = pc_q;
    assign misaligned  = mis_q;
    assign instr_valid = !empty;
    assign instr       = empty ? NOP_INSTR : head.instr;
    assign instr_pc    = empty ? 32'h0000_0000 : head.pc;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the prefetch buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port fetch_en  input  1  meaning fetch permitted this cycle.
REQ-006 SHALL have port imem_addr  output  32  meaning the byte address to the combinational instruction memory.
REQ-007 SHALL have port imem_rdata  input  32  meaning the instruction word returned the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  meaning a branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  meaning the redirect target.
REQ-010 SHALL have port instr_valid  output  1  meaning the buffer head is valid.
REQ-011 SHALL have port instr_ready  input  1  meaning decode accepts the head this cycle.
REQ-012 SHALL have port instr  output  32  meaning the head instruction word.
REQ-013 SHALL have port instr_pc  output  32  meaning the head instruction address.
REQ-014 SHALL have port misaligned  output  1  meaning a one-cycle pulse for a redirect_pc with [1:0] != 0.

Function
REQ-015 SHALL drive imem_addr = pc combinationally from the internal pc register.
REQ-016 SHALL have FSM states IDLE (fetch_en=0), FETCH (fetch_en=1, buffer not full), HOLD (buffer full, no pop).
REQ-017 SHALL transition to IDLE whenever fetch_en=0, to HOLD when a push fills the buffer with no pop, and to FETCH otherwise.
REQ-018 SHALL push {pc, imem_rdata} and advance pc by 4 in a cycle where fetch_en=1, no redirect, and the buffer is not full or pops this cycle.
REQ-019 SHALL wrap pc modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-020 SHALL pop the head on instr_valid && instr_ready; simultaneous push and pop on a full buffer SHALL keep the count unchanged.
REQ-021 SHALL present the head on instr/instr_pc with one-cycle latency from its push; instr_valid SHALL equal buffer non-empty.
REQ-022 SHALL drive instr = 32'h0000_0013 (NOP) and instr_pc = 0 whenever instr_valid=0.
REQ-023 SHALL on redirect_valid flush all entries, load pc = {redirect_pc[31:2], 2'b00}, and suppress push and pop that cycle; redirect has priority over all other events.
REQ-024 SHALL assert misaligned for exactly the redirect cycle's following cycle when redirect_pc[1:0] != 0.
REQ-025 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-026 SHALL stop pushing but keep pc, buffer contents, and pops active while fetch_en=0.

Reset
REQ-027 SHALL on rst_n=0 asynchronously set pc=RESET_PC, buffer empty, state IDLE, instr_valid=0, instr=NOP, instr_pc=0, misaligned=0.
REQ-028 SHALL discard an in-flight push and any pending redirect when reset asserts mid-operation.
REQ-029 SHALL issue the first push on the first rising edge after rst_n deasserts with fetch_en=1.

Structure
REQ-030 SHALL place fetch_entry_t (pc, instr), the NOP constant, and the FSM state enum in shared package fetch_pkg.
REQ-031 SHALL implement the buffer as sub-module fetch_fifo (push, pop, flush, full, empty, head) parameterised by BUF_DEPTH.

Verification
REQ-032 SHALL cover reset release, fetch_en=1, instr_ready=1, memory word0=0x000000B3 and word1=0x00108133 -> instr 0x000000B3/pc 0x00 then 0x00108133/pc 0x04 on consecutive cycles.
REQ-033 SHALL cover instr_ready=0 for 5 cycles -> buffer fills to 2, state HOLD, imem_addr frozen at 0x08, head stays pc 0x00.
REQ-034 SHALL cover redirect_valid with redirect_pc=0x0C while full -> next cycle instr_valid=0, then instr 0x00400213/pc 0x0C.
REQ-035 SHALL cover redirect_pc=0x0000_0013 -> misaligned pulse for one cycle, next fetch at 0x10.
REQ-036 SHALL cover RESET_PC=0xFFFF_FFFC -> entries at pc 0xFFFF_FFFC then 0x0000_0000.
REQ-037 SHALL cover rst_n low during a simultaneous push/pop -> all outputs at reset values immediately, no stale entry after release.
